trigger_sequencer: RTL and testbench

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

---
 rtl/trigger_sequencer_pkg.sv | 13 +
 rtl/trigger_sequencer_sync_2ff.sv | 25 ++
 rtl/trigger_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_sequencer_pkg.sv
// Shared types for the trigger sequencer: FSM state encodings and
// overrun counter limit.
package trigger_sequencer_pkg;

    typedef enum logic [1:0] {
        TRIG_SEQ_IDLE  = 2'd0,
        TRIG_SEQ_DELAY = 2'd1,
        TRIG_SEQ_PULSE = 2'd2
    } trig_seq_state_e;

    localparam logic [7:0] OVERRUN_MAX = 8'hFF;

endpackage

// File: rtl/trigger_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing a level signal into the trigger clock
// domain; both flops clear asynchronously on reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/trigger_sequencer.sv
// Match-triggered multi-pulse sequencer with per-pulse delay and width.
// Define TRIGGER_SEQ_OVERRUN_EN to build the ignored-match counter.
module trigger_sequencer
    import trigger_sequencer_pkg::*;
#(
    parameter int pNUM_TRIGGER_PULSES = 8,
    parameter int pNUM_TRIGGER_WIDTH  = 4,
    parameter int pDELAY_WIDTH        = 24,
    parameter int pWIDTH_WIDTH        = 24
) (
    input  logic                                        trigger_clk,
    input  logic                                        reset_n_i,
    input  logic                                        I_enable,
    input  logic                                        I_match,
    input  logic [pNUM_TRIGGER_PULSES*pDELAY_WIDTH-1:0] I_trigger_delay,
    input  logic [pNUM_TRIGGER_PULSES*pWIDTH_WIDTH-1:0] I_trigger_width,
    input  logic [pNUM_TRIGGER_WIDTH-1:0]               I_num_triggers,
    output logic                                        O_trigger,
    output logic                                        O_busy,
    output logic                                        O_done,
    output logic [7:0]                                  O_overrun_count
);

    localparam int pCNT_W = (pDELAY_WIDTH > pWIDTH_WIDTH) ?
                            pDELAY_WIDTH : pWIDTH_WIDTH;
    localparam int pIDX_W = pNUM_TRIGGER_WIDTH;
    localparam logic [pIDX_W-1:0] NUM_MAX = pIDX_W'(pNUM_TRIGGER_PULSES);

    trig_seq_state_e state_q, state_d;

    logic [pCNT_W-1:0] cnt_q, cnt_d;
    logic [pIDX_W-1:0] idx_q, idx_d;
    logic [pIDX_W-1:0] idx_nxt;
    logic [pIDX_W-1:0] sh_num_q;
    logic [pIDX_W-1:0] num_clamp;
    logic [pNUM_TRIGGER_PULSES*pDELAY_WIDTH-1:0] sh_delay_q;
    logic [pNUM_TRIGGER_PULSES*pWIDTH_WIDTH-1:0] sh_width_q;

    logic                    en_sync;
    logic                    start;
    logic                    last;
    logic                    busy;
    logic                    trig_q, trig_d;
    logic                    done_q, done_d;
    logic [pWIDTH_WIDTH-1:0] width_sel;
    logic [pWIDTH_WIDTH-1:0] width_m1;
    logic [pDELAY_WIDTH-1:0] delay_nxt;
    logic [pCNT_W-1:0]       width_cnt;

    sync_2ff u_sync_enable (
        .clk_i  (trigger_clk),
        .rst_ni (reset_n_i),
        .d_i    (I_enable),
        .q_o    (en_sync)
    );

    // Zero and oversized counts are folded into the legal 1..N range.
    always_comb begin
        num_clamp = I_num_triggers;
        if (I_num_triggers == '0) begin
            num_clamp = pIDX_W'(1);
        end else if (I_num_triggers > NUM_MAX) begin
            num_clamp = NUM_MAX;
        end
    end

    assign busy      = (state_q != TRIG_SEQ_IDLE) || done_q;
    assign start     = (state_q == TRIG_SEQ_IDLE) && !done_q &&
                       en_sync && I_match;
    assign idx_nxt   = idx_q + pIDX_W'(1);
    assign last      = (idx_q == sh_num_q - pIDX_W'(1));
    assign width_sel = sh_width_q[int'(idx_q)*pWIDTH_WIDTH +: pWIDTH_WIDTH];
    assign delay_nxt = sh_delay_q[int'(idx_nxt)*pDELAY_WIDTH +: pDELAY_WIDTH];
    assign width_m1  = width_sel - pWIDTH_WIDTH'(1);
    assign width_cnt = (width_sel == '0) ? '0 : pCNT_W'(width_m1);

    always_ff @(posedge trigger_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= TRIG_SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        unique case (state_q)
            TRIG_SEQ_IDLE: begin
                if (start) begin
                    state_d = TRIG_SEQ_DELAY;
                    cnt_d   = pCNT_W'(I_trigger_delay[pDELAY_WIDTH-1:0]);
                    idx_d   = '0;
                end
            end
            TRIG_SEQ_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = TRIG_SEQ_PULSE;
                    cnt_d   = width_cnt;
                end else begin
                    cnt_d = cnt_q - pCNT_W'(1);
                end
            end
            TRIG_SEQ_PULSE: begin
                if (cnt_q == '0) begin
                    if (last) begin
                        state_d = TRIG_SEQ_IDLE;
                    end else begin
                        state_d = TRIG_SEQ_DELAY;
                        idx_d   = idx_nxt;
                        cnt_d   = pCNT_W'(delay_nxt);
                    end
                end else begin
                    cnt_d = cnt_q - pCNT_W'(1);
                end
            end
            default: state_d = TRIG_SEQ_IDLE;
        endcase
        if (!en_sync) begin
            state_d = TRIG_SEQ_IDLE;
        end
    end

    always_comb begin
        trig_d = 1'b0;
        done_d = 1'b0;
        if (en_sync) begin
            unique case (state_q)
                TRIG_SEQ_DELAY: trig_d = (cnt_q == '0);
                TRIG_SEQ_PULSE: begin
                    trig_d = (cnt_q != '0);
                    done_d = (cnt_q == '0) && last;
                end
                default: begin
                    trig_d = 1'b0;
                    done_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge trigger_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_num_q   <= '0;
            sh_delay_q <= '0;
            sh_width_q <= '0;
            trig_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            trig_q <= trig_d;
            done_q <= done_d;
            if (start) begin
                sh_num_q   <= num_clamp;
                sh_delay_q <= I_trigger_delay;
                sh_width_q <= I_trigger_width;
            end
        end
    end

    assign O_trigger = trig_q;
    assign O_done    = done_q;
    assign O_busy    = busy;

`ifdef TRIGGER_SEQ_OVERRUN_EN
    logic [7:0] ovr_q;

    always_ff @(posedge trigger_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ovr_q <= '0;
        end else if (I_match && busy && (ovr_q != OVERRUN_MAX)) begin
            ovr_q <= ovr_q + 8'd1;
        end
    end

    assign O_overrun_count = ovr_q;
`else
    assign O_overrun_count = 8'd0;
`endif

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: per-edge traces of the outputs
// are compared against hand-derived bit masks.
module tb_trigger_sequencer;

    localparam int NP = 8;
    localparam int DW = 24;
    localparam int WW = 24;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             match;
    logic [NP*DW-1:0] dly;
    logic [NP*WW-1:0] wid;
    logic [3:0]       num;
    logic             trig;
    logic             busy;
    logic             done;
    logic [7:0]       ovr;

    logic [63:0] th;
    logic [63:0] dh;
    logic [63:0] bh;
    int          total;
    int          passed;
    int          exp_ovr;

    trigger_sequencer dut (
        .trigger_clk     (clk),
        .reset_n_i       (rst_n),
        .I_enable        (en),
        .I_match         (match),
        .I_trigger_delay (dly),
        .I_trigger_width (wid),
        .I_num_triggers  (num),
        .O_trigger       (trig),
        .O_busy          (busy),
        .O_done          (done),
        .O_overrun_count (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input int j);
        th[j] = trig;
        dh[j] = done;
        bh[j] = busy;
    endtask

    task automatic start_seq();
        th = '0;
        dh = '0;
        bh = '0;
        match = 1'b1;
        tick();
        match = 1'b0;
        rec(0);
    endtask

    task automatic cont(input int from, input int to);
        for (int j = from; j <= to; j++) begin
            tick();
            rec(j);
        end
    endtask

    task automatic cfg_all(input int n, input int d, input int w);
        num = 4'(n);
        for (int i = 0; i < NP; i++) begin
            dly[i*DW +: DW] = DW'(d);
            wid[i*WW +: WW] = WW'(w);
        end
    endtask

    task automatic cfg_one(input int i, input int d, input int w);
        dly[i*DW +: DW] = DW'(d);
        wid[i*WW +: WW] = WW'(w);
    endtask

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int rises(input logic [63:0] v);
        int   c;
        logic p;
        c = 0;
        p = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (v[i] && !p) c++;
            p = v[i];
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        match  = 1'b0;
        th     = '0;
        dh     = '0;
        bh     = '0;
        cfg_all(1, 0, 0);
`ifdef TRIGGER_SEQ_OVERRUN_EN
        exp_ovr = 3;
`else
        exp_ovr = 0;
`endif

        #3;
        check("rst_trig", 64'(trig), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ovr", 64'(ovr), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Synchronizer still filling: matches on edges 1 and 2 are dropped.
        match = 1'b1;
        tick();
        check("sync_e1_busy", 64'(busy), 64'd0);
        tick();
        check("sync_e2_busy", 64'(busy), 64'd0);
        match = 1'b0;
        tick();

        cfg_all(1, 0, 0);
        start_seq();
        cont(1, 7);
        check("min_trig", th, rng(1, 1));
        check("min_done", dh, rng(2, 2));
        check("min_busy", bh, rng(0, 2));

        cfg_all(3, 0, 0);
        cfg_one(0, 5, 3);
        cfg_one(1, 2, 1);
        cfg_one(2, 0, 4);
        start_seq();
        cont(1, 23);
        check("seq3_trig", th, rng(6, 8) | rng(12, 12) | rng(14, 17));
        check("seq3_done", dh, rng(18, 18));
        check("seq3_busy", bh, rng(0, 18));

        cfg_all(12, 1, 1);
        start_seq();
        cont(1, 31);
        check("clamp12_pulses", 64'(rises(th)), 64'd8);
        check("clamp12_done", dh, rng(24, 24));

        cfg_all(0, 1, 1);
        start_seq();
        cont(1, 7);
        check("zero_pulses", 64'(rises(th)), 64'd1);
        check("zero_done", dh, rng(3, 3));

        cfg_all(1, 3, 3);
        start_seq();
        for (int j = 1; j <= 11; j++) begin
            match = (j == 2) || (j == 5) || (j == 7);
            tick();
            match = 1'b0;
            rec(j);
        end
        check("ovr_done", dh, rng(7, 7));
        check("ovr_busy", bh, rng(0, 7));
        check("ovr_count", 64'(ovr), 64'(exp_ovr));

        cfg_all(4, 1, 10);
        start_seq();
        cont(1, 16);
        en = 1'b0;
        cont(17, 24);
        check("drop_trig", th, rng(2, 11) | rng(14, 18));
        check("drop_done", dh, 64'd0);
        check("drop_busy", bh, rng(0, 18));
        en = 1'b1;
        tick();
        tick();
        tick();
        start_seq();
        cont(1, 51);
        check("fresh_first", th & rng(0, 13), rng(2, 11));
        check("fresh_pulses", 64'(rises(th)), 64'd4);
        check("fresh_done", dh, rng(48, 48));

        cfg_all(1, 0, 20);
        start_seq();
        cont(1, 5);
        check("pre_rst_trig", 64'(trig), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_trig", 64'(trig), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_ovr", 64'(ovr), 64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        tick();

        cfg_all(2, 0, 0);
        cfg_one(0, 2, 2);
        cfg_one(1, 3, 2);
        start_seq();
        cont(1, 1);
        cfg_all(8, 0, 7);
        cont(2, 14);
        check("shadow_trig", th, rng(3, 4) | rng(9, 10));
        check("shadow_done", dh, rng(11, 11));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
